// File: rtl/load_align_unit_pkg.sv
// Shared types for the load alignment path: access sizes, FSM states, helpers.
package load_align_unit_pkg;

  typedef logic        u1;
  typedef logic [2:0]  u3;
  typedef logic [63:0] u64;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    StIdle,
    StRd0,
    StRd1,
    StResp
  } la_state_t;

  // Number of bytes moved by an access of the given size.
  function automatic int unsigned msize_bytes(msize_t m);
    return 32'd1 << m;
  endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Request, read-beat and response channels of the load alignment unit.
interface load_align_unit_if #(
  parameter int unsigned DATA_W = 64
) ();
  import load_align_unit_pkg::*;

  u1                 req_valid;
  u1                 req_ready;
  u64                req_addr;
  msize_t            req_msize;
  u1                 req_unsigned;
  u1                 bus_valid;
  u64                bus_addr;
  u1                 bus_data_ok;
  logic [DATA_W-1:0] bus_data;
  u1                 resp_valid;
  u1                 resp_ready;
  logic [DATA_W-1:0] resp_data;
  u1                 resp_err;

  // Environment side: issues requests, serves beats, consumes results.
  modport master (
    output req_valid, req_addr, req_msize, req_unsigned,
    input  req_ready,
    input  bus_valid, bus_addr,
    output bus_data_ok, bus_data,
    input  resp_valid, resp_data, resp_err,
    output resp_ready
  );

  // Unit side.
  modport slave (
    input  req_valid, req_addr, req_msize, req_unsigned,
    output req_ready,
    output bus_valid, bus_addr,
    input  bus_data_ok, bus_data,
    output resp_valid, resp_data, resp_err,
    input  resp_ready
  );

endinterface

// File: rtl/load_align_unit_extract.sv
// Combinational byte extraction and sign/zero extension from a two-beat window.
module load_extract
  import load_align_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  localparam int unsigned OFF_W = $clog2(DATA_W / 8),
  localparam int unsigned IDX_W = $clog2(2 * DATA_W)
) (
  input  logic [2*DATA_W-1:0] i_word,
  input  logic [OFF_W-1:0]    i_off,
  input  msize_t              i_msize,
  input  logic                i_unsigned,
  output logic [DATA_W-1:0]   o_data
);

  int unsigned      w_nbits;
  logic             w_fill;
  logic [IDX_W-1:0] w_base;

  // Shift the window down by the byte offset, keep n bytes, extend the rest.
  always_comb begin
    w_nbits = 8 * msize_bytes(i_msize);
    // A full-width access passes straight through.
    if (w_nbits > DATA_W) w_nbits = DATA_W;
    w_base = IDX_W'({i_off, 3'b000});
    w_fill = i_unsigned ? 1'b0 : i_word[w_base + IDX_W'(w_nbits - 1)];
    for (int i = 0; i < int'(DATA_W); i++) begin
      o_data[i] = (i < int'(w_nbits)) ? i_word[w_base + IDX_W'(i)] : w_fill;
    end
  end

endmodule

// File: rtl/load_align_unit.sv
// Load formatter: issues one or two aligned read beats per load, merges and
// extends the addressed bytes, and returns a registered result.
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int unsigned DATA_W           = 64,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input logic              i_clk,
  input logic              i_reset,  // active low, asynchronous
  load_align_unit_if.slave io_lau
);

  localparam int unsigned B     = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(B);

  la_state_t         r_state, w_state_d;
  u64                r_addr;
  msize_t            r_msize;
  u1                 r_unsigned, r_cross, r_err;
  logic [DATA_W-1:0] r_beat0, r_resp_data;

  logic [OFF_W-1:0]    w_req_off;
  u1                   w_req_cross, w_req_bad;
  u64                  w_base_addr;
  logic [2*DATA_W-1:0] w_merged;
  logic [DATA_W-1:0]   w_ext;

  // Classify the incoming request and build the beat window for extraction.
  always_comb begin
    w_req_off   = io_lau.req_addr[OFF_W-1:0];
    w_req_cross = (32'(w_req_off) + msize_bytes(io_lau.req_msize)) > B;
    w_req_bad   = ((DATA_W == 32) && (io_lau.req_msize == MSIZE8)) ||
                  (!ALLOW_MISALIGNED && w_req_cross);
    w_base_addr = {r_addr[63:OFF_W], {OFF_W{1'b0}}};
    // Second beat sits above the first; non-crossing loads see zeros there.
    w_merged    = (r_state == StRd1) ? {io_lau.bus_data, r_beat0}
                                     : {{DATA_W{1'b0}}, io_lau.bus_data};
  end

  load_extract #(
    .DATA_W (DATA_W)
  ) u_extract (
    .i_word     (w_merged),
    .i_off      (r_addr[OFF_W-1:0]),
    .i_msize    (r_msize),
    .i_unsigned (r_unsigned),
    .o_data     (w_ext)
  );

  // Next-state and handshake outputs.
  always_comb begin
    w_state_d        = r_state;
    io_lau.req_ready = 1'b0;
    io_lau.bus_valid = 1'b0;
    io_lau.bus_addr  = '0;
    unique case (r_state)
      StIdle: begin
        io_lau.req_ready = 1'b1;
        if (io_lau.req_valid) w_state_d = w_req_bad ? StResp : StRd0;
      end
      StRd0: begin
        io_lau.bus_valid = 1'b1;
        io_lau.bus_addr  = w_base_addr;
        if (io_lau.bus_data_ok) w_state_d = r_cross ? StRd1 : StResp;
      end
      StRd1: begin
        io_lau.bus_valid = 1'b1;
        io_lau.bus_addr  = w_base_addr + 64'(B);
        if (io_lau.bus_data_ok) w_state_d = StResp;
      end
      StResp: begin
        if (io_lau.resp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    io_lau.resp_valid = (r_state == StResp);
    io_lau.resp_data  = r_resp_data;
    io_lau.resp_err   = r_err;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  // Request latch, beat buffer and result register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_addr      <= '0;
      r_msize     <= MSIZE1;
      r_unsigned  <= 1'b0;
      r_cross     <= 1'b0;
      r_err       <= 1'b0;
      r_beat0     <= '0;
      r_resp_data <= '0;
    end else begin
      if (r_state == StIdle && io_lau.req_valid) begin
        r_addr      <= io_lau.req_addr;
        r_msize     <= io_lau.req_msize;
        r_unsigned  <= io_lau.req_unsigned;
        r_cross     <= w_req_cross;
        r_err       <= w_req_bad;
        r_beat0     <= '0;
        r_resp_data <= '0;
      end
      if (r_state == StRd0 && io_lau.bus_data_ok) begin
        r_beat0 <= io_lau.bus_data;
        if (!r_cross) r_resp_data <= w_ext;
      end
      if (r_state == StRd1 && io_lau.bus_data_ok) r_resp_data <= w_ext;
    end
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised load-data formatter for the memory stage; generalises the combinational byte-lane selection and sign/zero extension.
- Accepts one load request and issues aligned read beats on the data bus: one beat for aligned or in-beat accesses, two beats when the access crosses a beat boundary.
- Merges the beats, extracts the addressed bytes and sign/zero-extends them to the result width.
- Returns a registered result with a valid/ready handshake towards writeback.

Parameters:
DATA_W, 64, bus beat and result width in bits; 32 or 64 only.
ALLOW_MISALIGNED, 1, when 1 split beat-crossing loads into two beats; when 0 flag them as errors with no bus traffic.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset.
req_valid  in  1  load request present.
req_ready  out  1  unit can accept a request (high only in IDLE).
req_addr  in  64  byte address.
req_msize  in  msize_t  MSIZE1/2/4/8.
req_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
bus_valid  out  1  read beat request.
bus_addr  out  64  beat-aligned address (low log2(DATA_W/8) bits zero).
bus_data_ok  in  1  beat data returned this cycle; ends the beat.
bus_data  in  DATA_W  returned beat.
resp_valid  out  1  result available.
resp_ready  in  1  consumer accepts the result.
resp_data  out  DATA_W  extended load result.
resp_err  out  1  request rejected (misaligned with ALLOW_MISALIGNED=0, or MSIZE8 with DATA_W=32); resp_data=0.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; req_ready=1; bus_valid=0; bus_addr=0; resp_valid=0; resp_data=0; resp_err=0; beat buffers cleared.
- Derived values:
  - B = DATA_W/8; off = req_addr mod B; n = 1<<msize.
  - cross = (off+n > B).
- FSM states: IDLE, RD0, RD1, RESP.
- IDLE:
  - On req_valid, latch addr/msize/unsigned.
  - If illegal size, or cross with ALLOW_MISALIGNED=0: go to RESP with err=1.
  - Otherwise go to RD0.
- RD0:
  - bus_valid=1, bus_addr=addr & ~(B-1).
  - bus_valid and bus_addr are held stable until bus_data_ok.
  - On bus_data_ok, latch beat0, then go to RD1 if cross, else to RESP.
- RD1:
  - bus_valid=1, bus_addr = aligned addr + B.
  - On bus_data_ok, latch beat1 and go to RESP.
- RESP:
  - resp_valid=1 with resp_data/resp_err stable.
  - When resp_ready is high, go to IDLE; resp_valid drops the next cycle.
- Merge and extend:
  - w = {beat1, beat0} (beat1=0 if not cross), shifted right by off*8.
  - Take the low n bytes; fill upper bits with 0 when unsigned, else with bit n*8-1.
  - MSIZE8 with DATA_W=64 passes through unchanged.
- Latency, aligned load with bus_data_ok in the first bus cycle: request accepted in cycle 0, bus_valid in cycle 1, resp_valid in cycle 2.
- Latency, crossing load: one extra bus cycle minimum.
- bus_data_ok is sampled only in RD0/RD1; it is ignored elsewhere.
- req_ready=0 outside IDLE; there is no request buffering or back-to-back acceptance from RESP.
- Reset asserted mid-transaction aborts immediately: bus_valid drops asynchronously and no response is produced.
- resp_data is registered, with no combinational path from bus_data.

Decomposition:
- Shared package (common) holds:
  - msize_t and the MSIZE1/2/4/8 encodings.
  - u1/u3/u64.
  - A new la_state_t enum (IDLE, RD0, RD1, RESP).
- Sub-module load_extract (combinational):
  - Inputs: merged 2*DATA_W word, off, msize, unsigned.
  - Output: the extended result.
  - Reusable by the store/AMO path.

Test Plan:
- Aligned LB: addr=0x1003, MSIZE1, signed, bus_data=0x00000000_80000000.
  - Required response: one beat at 0x1000; resp_data=0xFFFFFFFF_FFFFFF80.
- Same access with req_unsigned=1.
  - Required response: resp_data=0x80.
- Crossing LW: addr=0x2006, MSIZE4, signed.
  - Stimulus: beat0=0xBBAA0000_00000000 from 0x2000, beat1=0x00000000_0000DDCC from 0x2008.
  - Required response: two beats; resp_data=0xFFFFFFFF_DDCCBBAA.
- ALLOW_MISALIGNED=0, same crossing LW.
  - Required response: no bus_valid; resp_valid with resp_err=1, resp_data=0.
- Stalls: bus_data_ok delayed 3 cycles; resp_ready low 2 cycles.
  - Required response: bus_addr and resp_data stay stable; req_ready stays 0 until RESP completes.
- Reset pulled low while in RD1.
  - Required response: bus_valid=0 and resp_valid=0 asynchronously; next request after reset behaves as the first scenario.
